cordic_atan2: RTL and testbench



---
 rtl/cordic_atan2_if.sv | 27 ++
 rtl/cordic_atan2.sv | 204 ++++++++++++++++++++
 tb/tb_cordic_atan2.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/cordic_atan2_if.sv
// Request/result bundle for the CORDIC engine: start with operands in, busy/done with results out.
// The master drives a request and the slave (the engine) returns held results and a done pulse.
interface cordic_atan2_if #(
  parameter int DATA_W  = 24,
  parameter int ANGLE_W = 16
);
  logic                      crd_start;
  logic                      crd_mode;
  logic signed [DATA_W-1:0]  x_in;
  logic signed [DATA_W-1:0]  y_in;
  logic signed [ANGLE_W-1:0] z_in;
  logic                      crd_busy;
  logic                      crd_done;
  logic signed [DATA_W-1:0]  crd_x;
  logic signed [DATA_W-1:0]  crd_y;
  logic signed [ANGLE_W-1:0] crd_angle;

  modport master (
    output crd_start, crd_mode, x_in, y_in, z_in,
    input  crd_busy, crd_done, crd_x, crd_y, crd_angle
  );

  modport slave (
    input  crd_start, crd_mode, x_in, y_in, z_in,
    output crd_busy, crd_done, crd_x, crd_y, crd_angle
  );
endinterface

// File: rtl/cordic_atan2.sv
// Iterative full-circle CORDIC: vectoring (atan2 + magnitude) or rotation, one micro-rotation
// per clock, followed by gain compensation and saturation of the x/y results.
module cordic_atan2 #(
  parameter int DATA_W     = 24,
  parameter int ANGLE_W    = 16,
  parameter int ITERATIONS = 16,
  parameter int GAIN_FRAC  = 14,
  parameter int GAIN       = 9949
) (
  input logic           clk,
  input logic           rst_n,
  cordic_atan2_if.slave crd
);
  localparam int WIDE_W = DATA_W + 2;
  localparam int PROD_W = WIDE_W + GAIN_FRAC + 1;
  localparam int IDX_W  = $clog2(ITERATIONS);

  typedef logic signed [DATA_W-1:0]  data_t;
  typedef logic signed [WIDE_W-1:0]  wide_t;
  typedef logic signed [ANGLE_W-1:0] angle_t;
  typedef logic signed [PROD_W-1:0]  prod_t;
  typedef logic        [IDX_W-1:0]   idx_t;
  typedef enum logic [1:0] {IDLE, ITER, SCALE, OUT} state_e;

  localparam angle_t QUARTER  = angle_t'(64'sd1 <<< (ANGLE_W - 2));
  localparam prod_t  GAIN_P   = prod_t'(GAIN);
  localparam data_t  DATA_MAX = data_t'({1'b0, {(DATA_W-1){1'b1}}});
  localparam data_t  DATA_MIN = data_t'({1'b1, {(DATA_W-1){1'b0}}});

  // atan(1/n) in Q<frac> by its alternating series; only called with n >= 2.
  function automatic longint atan_inv(longint n, int frac);
    longint pw, acc;
    pw  = (64'sd1 <<< frac) / n;
    acc = 64'sd0;
    for (int k = 0; k < 64; k++) begin
      if (k % 2 == 0) acc += pw / longint'(2 * k + 1);
      else            acc -= pw / longint'(2 * k + 1);
      pw = pw / (n * n);
    end
    return acc;
  endfunction

  // Binary-angle table entry, normalised against pi/4 (Machin) so no real math is needed.
  function automatic angle_t atan_entry(int idx);
    int     frac;
    longint a45, ai;
    frac = 62 - ANGLE_W;
    a45  = 64'sd4 * atan_inv(64'sd5, frac) - atan_inv(64'sd239, frac);
    if (idx == 0) return angle_t'(QUARTER >>> 1);
    ai = atan_inv(64'sd1 <<< idx, frac);
    return angle_t'(((ai <<< (ANGLE_W - 3)) + a45 / 64'sd2) / a45);
  endfunction

  function automatic data_t sat(prod_t p);
    prod_t s;
    s = p >>> GAIN_FRAC;
    if (s > prod_t'(DATA_MAX)) return DATA_MAX;
    if (s < prod_t'(DATA_MIN)) return DATA_MIN;
    return data_t'(s);
  endfunction

  angle_t atan_lut [ITERATIONS];
  for (genvar g = 0; g < ITERATIONS; g++) begin : g_atan
    localparam angle_t ENTRY = atan_entry(g);
    assign atan_lut[g] = ENTRY;
  end

  state_e state_q, state_d;
  wide_t  x_q, x_d, y_q, y_d;
  angle_t z_q, z_d;
  idx_t   i_q, i_d;
  logic   mode_q, mode_d;
  prod_t  px_q, px_d, py_q, py_d;
  data_t  x_out_q, x_out_d, y_out_q, y_out_d;
  angle_t ang_out_q, ang_out_d;
  logic   done_q, done_d;

  wide_t x_ext, y_ext, x_sh, y_sh;
  logic  zero_vec, dir_pos;

  assign x_ext    = wide_t'(crd.x_in);
  assign y_ext    = wide_t'(crd.y_in);
  assign x_sh     = x_q >>> i_q;
  assign y_sh     = y_q >>> i_q;
  assign zero_vec = !crd.crd_mode && (crd.x_in == '0) && (crd.y_in == '0);
  assign dir_pos  = mode_q ? z_q[ANGLE_W-1] : !y_q[WIDE_W-1];

  // NOTE: reset is synchronous (sampled only on the rising edge) and all state uses <=,
  // so every register observes the same pre-edge values regardless of block order.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (crd.crd_start) state_d = zero_vec ? OUT : ITER;
      ITER:    if (i_q == idx_t'(ITERATIONS - 1)) state_d = SCALE;
      SCALE:   state_d = OUT;
      OUT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    crd.crd_busy = (state_q != IDLE);
  end

  // NOTE: every _d variable takes its hold value first, so no path through the case
  // leaves one unassigned and no latch can be inferred.
  always_comb begin
    x_d       = x_q;
    y_d       = y_q;
    z_d       = z_q;
    i_d       = i_q;
    mode_d    = mode_q;
    px_d      = px_q;
    py_d      = py_q;
    x_out_d   = x_out_q;
    y_out_d   = y_out_q;
    ang_out_d = ang_out_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: if (crd.crd_start) begin
        mode_d = crd.crd_mode;
        i_d    = '0;
        x_d    = x_ext;
        y_d    = y_ext;
        z_d    = '0;
        // Fold the input into the right half-plane so the ~100 deg micro-rotation range suffices.
        if (!crd.crd_mode) begin
          if (zero_vec) begin
            px_d = '0;
            py_d = '0;
          end else if (crd.x_in < 0 && crd.y_in >= 0) begin
            x_d = y_ext;  y_d = -x_ext; z_d = QUARTER;
          end else if (crd.x_in < 0) begin
            x_d = -y_ext; y_d = x_ext;  z_d = -QUARTER;
          end
        end else begin
          z_d = crd.z_in;
          if (crd.z_in > QUARTER) begin
            x_d = -y_ext; y_d = x_ext;  z_d = crd.z_in - QUARTER;
          end else if (crd.z_in < -QUARTER) begin
            x_d = y_ext;  y_d = -x_ext; z_d = crd.z_in + QUARTER;
          end
        end
      end
      ITER: begin
        if (dir_pos) begin
          x_d = x_q + y_sh; y_d = y_q - x_sh; z_d = z_q + atan_lut[i_q];
        end else begin
          x_d = x_q - y_sh; y_d = y_q + x_sh; z_d = z_q - atan_lut[i_q];
        end
        i_d = i_q + idx_t'(1);
      end
      SCALE: begin
        px_d = prod_t'(x_q) * GAIN_P;
        py_d = prod_t'(y_q) * GAIN_P;
      end
      OUT: begin
        x_out_d   = sat(px_q);
        y_out_d   = sat(py_q);
        ang_out_d = z_q;
        done_d    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      i_q       <= '0;
      mode_q    <= 1'b0;
      px_q      <= '0;
      py_q      <= '0;
      x_out_q   <= '0;
      y_out_q   <= '0;
      ang_out_q <= '0;
      done_q    <= 1'b0;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      z_q       <= z_d;
      i_q       <= i_d;
      mode_q    <= mode_d;
      px_q      <= px_d;
      py_q      <= py_d;
      x_out_q   <= x_out_d;
      y_out_q   <= y_out_d;
      ang_out_q <= ang_out_d;
      done_q    <= done_d;
    end
  end

  assign crd.crd_done  = done_q;
  assign crd.crd_x     = x_out_q;
  assign crd.crd_y     = y_out_q;
  assign crd.crd_angle = ang_out_q;
endmodule

// File: tb/tb_cordic_atan2.sv
// Directed bench for cordic_atan2: latency, handshake, accuracy, saturation, zero vector,
// ignored mid-operation start, back-to-back start and mid-operation reset.
module tb_cordic_atan2;
  localparam int DATA_W     = 24;
  localparam int ANGLE_W    = 16;
  localparam int ITERATIONS = 16;
  localparam int LAT        = ITERATIONS + 2;
  localparam int TIMEOUT    = 60;

  typedef logic signed [DATA_W-1:0]  data_t;
  typedef logic signed [ANGLE_W-1:0] angle_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  cordic_atan2_if #(.DATA_W(DATA_W), .ANGLE_W(ANGLE_W)) crd ();

  cordic_atan2 #(
    .DATA_W(DATA_W), .ANGLE_W(ANGLE_W), .ITERATIONS(ITERATIONS),
    .GAIN_FRAC(14), .GAIN(9949)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .crd(crd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_cmp++;
    assert (act === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic check_near(input string tag, input logic signed [63:0] act,
                            input longint exp, input longint tol);
    logic ok;
    ok = (act >= exp - tol) && (act <= exp + tol);
    n_cmp++;
    assert (ok === 1'b1) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d +/- %0d", tag, act, exp, tol);
    end
  endtask

  // Angle comparison modulo 2^ANGLE_W (wrap at +/-180 deg).
  task automatic check_ang(input string tag, input angle_t act, input int exp, input int tol);
    angle_t d;
    logic   ok;
    d  = act - angle_t'(exp);
    ok = (int'(d) >= -tol) && (int'(d) <= tol);
    n_cmp++;
    assert (ok === 1'b1) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d +/- %0d (mod 2^%0d)", tag, act, exp, tol, ANGLE_W);
    end
  endtask

  task automatic set_inputs(input logic mode, input int x, input int y, input int z);
    crd.crd_mode = mode;
    crd.x_in     = data_t'(x);
    crd.y_in     = data_t'(y);
    crd.z_in     = angle_t'(z);
  endtask

  // Leaves the bench at the falling edge right after the edge that sampled start (edge 0).
  task automatic start_op(input logic mode, input int x, input int y, input int z);
    @(negedge clk);
    set_inputs(mode, x, y, z);
    crd.crd_start = 1'b1;
    @(negedge clk);
    crd.crd_start = 1'b0;
  endtask

  // Counts edges from edge 0 until done is seen; records busy/hold behaviour before done.
  task automatic wait_done(input int lat0, output int lat, output bit busy_ok, output bit hold_ok);
    data_t  sx, sy;
    angle_t sa;
    sx = crd.crd_x; sy = crd.crd_y; sa = crd.crd_angle;
    lat     = lat0;
    busy_ok = (crd.crd_busy === 1'b1);
    hold_ok = 1'b1;
    while (crd.crd_done !== 1'b1 && lat < TIMEOUT) begin
      @(negedge clk);
      lat++;
      if (crd.crd_done !== 1'b1) begin
        busy_ok &= (crd.crd_busy === 1'b1);
        hold_ok &= (crd.crd_x === sx) && (crd.crd_y === sy) && (crd.crd_angle === sa);
      end
    end
  endtask

  task automatic run_op(input string tag, input logic mode, input int x, input int y,
                        input int z, input int exp_lat);
    int lat;
    bit busy_ok, hold_ok;
    start_op(mode, x, y, z);
    wait_done(0, lat, busy_ok, hold_ok);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_busy_during"}, busy_ok, 1);
    check({tag, "_hold_before_done"}, hold_ok, 1);
    check({tag, "_busy_at_done"}, crd.crd_busy, 0);
  endtask

  task automatic end_pulse(input string tag);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, crd.crd_done, 0);
  endtask

  initial begin
    int lat, dones;
    bit busy_ok, hold_ok;

    crd.crd_start = 1'b0;
    set_inputs(1'b0, 0, 0, 0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_busy", crd.crd_busy, 0);
    check("reset_done", crd.crd_done, 0);
    check("reset_x", crd.crd_x, 0);
    check("reset_y", crd.crd_y, 0);
    check("reset_angle", crd.crd_angle, 0);

    run_op("vec_pos_x", 1'b0, 10000, 0, 0, LAT);
    check_ang("vec_pos_x_angle", crd.crd_angle, 0, 3);
    check_near("vec_pos_x_x", crd.crd_x, 10000, 7);
    check_near("vec_pos_x_y", crd.crd_y, 0, 4);
    end_pulse("vec_pos_x");

    run_op("vec_q2", 1'b0, -10000, 10000, 0, LAT);
    check_ang("vec_q2_angle", crd.crd_angle, 24576, 3);
    check_near("vec_q2_x", crd.crd_x, 14142, 9);
    end_pulse("vec_q2");

    run_op("vec_q3_edge", 1'b0, -10000, -1, 0, LAT);
    check_ang("vec_q3_edge_angle", crd.crd_angle, -32768, 3);
    check_near("vec_q3_edge_x", crd.crd_x, 10000, 7);

    run_op("vec_neg_y", 1'b0, 0, -20000, 0, LAT);
    check_ang("vec_neg_y_angle", crd.crd_angle, -16384, 3);
    check_near("vec_neg_y_x", crd.crd_x, 20000, 12);

    run_op("rot_90", 1'b1, 10000, 0, 16384, LAT);
    check_near("rot_90_x", crd.crd_x, 0, 4);
    check_near("rot_90_y", crd.crd_y, 10000, 7);
    check_ang("rot_90_resid", crd.crd_angle, 0, 3);

    run_op("rot_m135", 1'b1, 10000, 0, -24576, LAT);
    check_near("rot_m135_x", crd.crd_x, -7071, 6);
    check_near("rot_m135_y", crd.crd_y, -7071, 6);
    check_ang("rot_m135_resid", crd.crd_angle, 0, 3);

    run_op("sat", 1'b0, 8388607, 8388607, 0, LAT);
    check("sat_x", crd.crd_x, 8388607);
    check_ang("sat_angle", crd.crd_angle, 8192, 3);

    run_op("zero", 1'b0, 0, 0, 0, 1);
    check("zero_x", crd.crd_x, 0);
    check("zero_y", crd.crd_y, 0);
    check("zero_angle", crd.crd_angle, 0);
    end_pulse("zero");

    // Second start at cycle 5 must be dropped: one done carrying the first operation's result.
    start_op(1'b0, 10000, 0, 0);
    repeat (5) @(negedge clk);
    set_inputs(1'b0, -10000, 10000, 0);
    crd.crd_start = 1'b1;
    @(negedge clk);
    crd.crd_start = 1'b0;
    wait_done(6, lat, busy_ok, hold_ok);
    check("ignore_latency", lat, LAT);
    check_ang("ignore_angle", crd.crd_angle, 0, 3);
    check_near("ignore_x", crd.crd_x, 10000, 7);
    dones = 0;
    repeat (25) begin
      @(negedge clk);
      if (crd.crd_done === 1'b1) dones++;
    end
    check("ignore_no_second_done", dones, 0);

    // Start asserted in the done cycle is accepted: done-to-done spacing ITERATIONS+3.
    run_op("b2b_a", 1'b0, 0, -20000, 0, LAT);
    check_ang("b2b_a_angle", crd.crd_angle, -16384, 3);
    set_inputs(1'b1, 10000, 0, 16384);
    crd.crd_start = 1'b1;
    @(negedge clk);
    crd.crd_start = 1'b0;
    wait_done(0, lat, busy_ok, hold_ok);
    check("b2b_spacing", lat + 1, ITERATIONS + 3);
    check("b2b_busy_during", busy_ok, 1);
    check_near("b2b_b_y", crd.crd_y, 10000, 7);
    check_near("b2b_b_x", crd.crd_x, 0, 4);
    end_pulse("b2b_b");

    // Reset at cycle 9 aborts the operation: outputs cleared, no done afterwards.
    start_op(1'b0, 10000, 0, 0);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_busy", crd.crd_busy, 0);
    check("abort_done", crd.crd_done, 0);
    check("abort_x", crd.crd_x, 0);
    check("abort_y", crd.crd_y, 0);
    check("abort_angle", crd.crd_angle, 0);
    rst_n = 1'b1;
    dones = 0;
    repeat (30) begin
      @(negedge clk);
      if (crd.crd_done === 1'b1) dones++;
    end
    check("abort_no_done", dones, 0);
    run_op("after_abort", 1'b0, -10000, 10000, 0, LAT);
    check_ang("after_abort_angle", crd.crd_angle, 24576, 3);
    check_near("after_abort_x", crd.crd_x, 14142, 9);
    end_pulse("after_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
